// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
//
// Purpose:
//   Sits between the core and the memory port. While idle it forwards every
//   core access to memory. A write to the DMA trigger register (DMA_REG)
//   starts a block copy of DMA_LEN bytes from page P into DMA_DST. While the
//   copy runs, the engine owns the memory port and the core is locked out.
//
// Ports:
//   i_clk          single clock, all state changes on the rising edge
//   i_reset        synchronous active-high reset
//   i_cpu_mreq     core bus request
//   i_cpu_rd       core read strobe
//   i_cpu_wr       core write strobe
//   i_cpu_a        core address (16 bits)
//   i_cpu_dout     core write data (8 bits)
//   o_cpu_din      read data returned to the core (8 bits)
//   o_mem_mreq     memory port request
//   o_mem_rd       memory port read strobe
//   o_mem_wr       memory port write strobe
//   o_mem_a        memory port address (16 bits)
//   o_mem_dout     memory port write data (8 bits)
//   i_mem_din      memory port read data (8 bits)
//   o_dma_busy     high while the DMA engine owns the memory port
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG = 16'hFF46,
  parameter int          DMA_LEN = 160,
  parameter logic [15:0] DMA_DST = 16'hFE00
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_mreq,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_a,
  input  logic [7:0]  i_cpu_dout,
  output logic [7:0]  o_cpu_din,
  output logic        o_mem_mreq,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_a,
  output logic [7:0]  o_mem_dout,
  input  logic [7:0]  i_mem_din,
  output logic        o_dma_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RD,
    S_WR
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     r_state;
  logic [7:0] r_page;
  logic [7:0] r_index;
  logic [7:0] r_data;
  logic       r_busy;

  logic       w_regHit;
  logic       w_trigger;
  logic       w_regRead;
  logic [7:0] w_srcPage;

  // Any access that targets the trigger register is handled locally and
  // never reaches the memory port.
  assign w_regHit  = i_cpu_mreq && (i_cpu_a == DMA_REG);
  assign w_trigger = w_regHit && i_cpu_wr;
  assign w_regRead = w_regHit && i_cpu_rd;

  // Pages E0..FF are echoes of C0..DF, so fold them down before reading.
  assign w_srcPage = (r_page < 8'hE0) ? r_page : (r_page - 8'h20);

  assign o_dma_busy = r_busy;

  // Transfer sequencer. A trigger restarts the copy from index 0 no matter
  // where the engine is; a write in progress during that cycle still lands
  // because the memory strobes are decoded from the current state. Busy is
  // registered alongside the state so it is a clean state decode.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_index <= 8'h00;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
    end else if (w_trigger) begin
      r_page  <= i_cpu_dout;
      r_index <= 8'h00;
      r_state <= S_START;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
        end
        S_START: begin
          r_state <= S_RD;
          r_busy  <= 1'b1;
        end
        S_RD: begin
          r_data  <= i_mem_din;
          r_state <= S_WR;
          r_busy  <= 1'b1;
        end
        S_WR: begin
          if (r_index == LAST_IDX) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_index <= r_index + 8'h01;
            r_state <= S_RD;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port and core read-data mux. Idle is a straight passthrough;
  // during a transfer the core sees FF and its strobes are discarded. Reads
  // of the trigger register return the page in every state.
  always_comb begin
    o_mem_mreq = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mem_a    = 16'h0000;
    o_mem_dout = 8'h00;
    o_cpu_din  = 8'hFF;
    case (r_state)
      S_IDLE: begin
        if (!w_regHit) begin
          o_mem_mreq = i_cpu_mreq;
          o_mem_rd   = i_cpu_rd;
          o_mem_wr   = i_cpu_wr;
          o_mem_a    = i_cpu_a;
          o_mem_dout = i_cpu_dout;
          o_cpu_din  = i_mem_din;
        end
      end
      S_START: begin
        o_mem_mreq = 1'b0;
      end
      S_RD: begin
        o_mem_mreq = 1'b1;
        o_mem_rd   = 1'b1;
        o_mem_a    = {w_srcPage, r_index};
      end
      S_WR: begin
        o_mem_mreq = 1'b1;
        o_mem_wr   = 1'b1;
        o_mem_a    = DMA_DST + {8'h00, r_index};
        o_mem_dout = r_data;
      end
      default: begin
        o_mem_mreq = 1'b0;
      end
    endcase
    if (w_regRead) begin
      o_cpu_din = r_page;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_arbiter
//
// Purpose:
//   Self-checking bench for oam_dma_arbiter. A 64 KiB memory model sits on
//   the memory port. Stimulus pushes the expected memory reads, memory
//   writes, core read data and busy-run lengths into queues computed from
//   the transfer rules; a negedge monitor pops and compares whenever the DUT
//   presents a strobe or ends a busy run.
// ---------------------------------------------------------------------------
module tb_oam_dma_arbiter;

  localparam int          LEN = 160;
  localparam logic [15:0] REG = 16'hFF46;
  localparam logic [15:0] DST = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuMreq, cpuRd, cpuWr;
  logic [15:0] cpuA;
  logic [7:0]  cpuDout, cpuDin;
  logic        memMreq, memRd, memWr;
  logic [15:0] memA;
  logic [7:0]  memDout, memDin;
  logic        dmaBusy;

  always #5 clk = ~clk;

  oam_dma_arbiter #(
    .DMA_REG(REG),
    .DMA_LEN(LEN),
    .DMA_DST(DST)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_cpu_mreq (cpuMreq),
    .i_cpu_rd   (cpuRd),
    .i_cpu_wr   (cpuWr),
    .i_cpu_a    (cpuA),
    .i_cpu_dout (cpuDout),
    .o_cpu_din  (cpuDin),
    .o_mem_mreq (memMreq),
    .o_mem_rd   (memRd),
    .o_mem_wr   (memWr),
    .o_mem_a    (memA),
    .o_mem_dout (memDout),
    .i_mem_din  (memDin),
    .o_dma_busy (dmaBusy)
  );

  // Initial memory content, shared by the memory model and the reference.
  function automatic logic [7:0] initByte(input logic [15:0] a);
    return 8'((a * 37) ^ (a >> 8) ^ 16'h5C);
  endfunction

  // Memory model: filled on the first edge, then written by the port.
  logic [7:0] mem [0:65535];
  bit         memReady = 1'b0;
  assign memDin = mem[memA];

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 65536; i++) mem[i] <= initByte(16'(i));
      memReady <= 1'b1;
    end else if (memMreq && memWr) begin
      mem[memA] <= memDout;
    end
  end

  // Reference state and scoreboard queues.
  logic [7:0]  refMem [0:65535];
  logic [15:0] expRd[$];
  logic [23:0] expWr[$];
  logic [7:0]  expCpu[$];
  int          expBusy[$];
  int          runStart = 0;
  int          modelEnd = 0;
  logic [7:0]  modelPage = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit monOn = 1'b0;
  bit prevTrig = 1'b0;
  int runLen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actVal,
                             input logic [31:0] expVal);
    checks++;
    if (actVal !== expVal) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actVal, expVal, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] actVal);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%0h expected=none at cycle %0d", name, actVal, cyc);
  endtask

  // A transfer copies DMA_LEN bytes from the (echo-folded) page to DST.
  function automatic void pushTransfer(input logic [7:0] page);
    logic [7:0]  src;
    logic [15:0] sa;
    src = (page >= 8'hE0) ? page - 8'h20 : page;
    for (int i = 0; i < LEN; i++) begin
      sa = {src, 8'(i)};
      expRd.push_back(sa);
      expWr.push_back({DST + 16'(i), refMem[sa]});
    end
  endfunction

  // Drive one core cycle, record what the reference expects of it, then
  // advance past the edge and apply the edge's effect on the reference.
  task automatic applyStimulus(input logic r, input logic mreq, input logic rd,
                               input logic wr, input logic [15:0] a,
                               input logic [7:0] d);
    bit busyNow;
    busyNow = (cyc < modelEnd);
    rst = r; cpuMreq = mreq; cpuRd = rd; cpuWr = wr; cpuA = a; cpuDout = d;
    if (!r && mreq) begin
      if (a == REG) begin
        if (rd) expCpu.push_back(modelPage);
      end else if (!busyNow) begin
        if (rd) begin
          expRd.push_back(a);
          expCpu.push_back(refMem[a]);
        end
        if (wr) begin
          refMem[a] = d;
          expWr.push_back({a, d});
        end
      end else if (rd) begin
        expCpu.push_back(8'hFF);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      expRd.delete();
      expWr.delete();
      if (cyc <= modelEnd) begin
        expBusy.delete();
        expBusy.push_back(cyc - runStart);
        modelEnd = cyc;
      end
      modelPage = 8'h00;
    end else if (mreq && wr && a == REG) begin
      if (cyc > modelEnd) runStart = cyc;
      modelEnd = cyc + 1 + 2 * LEN;
      modelPage = d;
      expRd.delete();
      expWr.delete();
      pushTransfer(d);
      expBusy.delete();
      expBusy.push_back(modelEnd - runStart);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic randomCycle(input bit allowTrig);
    int          r;
    logic [15:0] a;
    logic [7:0]  d;
    r = $urandom_range(0, 99);
    a = 16'($urandom_range(0, 16'hDFFF));
    d = 8'($urandom);
    if (allowTrig && $urandom_range(0, 99) < 2)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, d);
    else if (r < 30) idleCycle();
    else if (r < 55) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00);
    else if (r < 80) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, d);
    else if (r < 92) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, REG, 8'h00);
    else idleCycle();
  endtask

  // mode 0: quiet core, 1: random traffic, 2: random traffic with early retriggers
  task automatic waitIdle(input int maxCycles, input int mode);
    int n;
    n = 0;
    while (dmaBusy && n < maxCycles) begin
      if (mode == 0) idleCycle();
      else randomCycle(mode == 2 && n < 100);
      n++;
    end
    checkOutput("waitIdle", 32'(dmaBusy), 32'h0);
  endtask

  // Monitor: compares every memory strobe, core read and busy run.
  always @(negedge clk) begin
    if (monOn) begin
      if (memMreq && memRd) begin
        if (expRd.size() == 0) reportUnexpected("memRdAddr", 32'(memA));
        else checkOutput("memRdAddr", 32'(memA), 32'(expRd.pop_front()));
      end
      if (memMreq && memWr) begin
        if (expWr.size() == 0) reportUnexpected("memWrAddrData", 32'({memA, memDout}));
        else checkOutput("memWrAddrData", 32'({memA, memDout}), 32'(expWr.pop_front()));
      end
      if (cpuMreq && cpuRd) begin
        if (expCpu.size() == 0) reportUnexpected("cpuDin", 32'(cpuDin));
        else checkOutput("cpuDin", 32'(cpuDin), 32'(expCpu.pop_front()));
      end
      if (prevTrig)
        checkOutput("startCycle", 32'({dmaBusy, memMreq, memRd, memWr}), 32'h8);
      prevTrig = cpuMreq && cpuWr && (cpuA == REG) && !rst;
      if (dmaBusy) begin
        runLen++;
      end else if (runLen != 0) begin
        if (expBusy.size() == 0) reportUnexpected("busyLen", 32'(runLen));
        else checkOutput("busyLen", 32'(runLen), 32'(expBusy.pop_front()));
        runLen = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) refMem[i] = initByte(16'(i));

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    monOn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    checkOutput("resetBusy", 32'(dmaBusy), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, REG, 8'h00);

    // Idle passthrough and source setup.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
    for (int i = 0; i < LEN; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'hC000 + 16'(i), 8'(i));

    // Full transfer from page C0 with core lockout traffic.
    $display("[TB] full transfer from page C0");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, 8'hC0);
    repeat (5) idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'hC000, 8'h77);
    repeat (20) randomCycle(1'b0);
    waitIdle(1000, 1);
    for (int i = 0; i < LEN; i++)
      checkOutput("dstByte", 32'(mem[DST + 16'(i)]), 32'(i));
    checkOutput("lockoutSrc", 32'(mem[16'hC000]), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, REG, 8'h00);

    // Echo fold.
    $display("[TB] echo fold page E1");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, 8'hE1);
    waitIdle(1000, 0);

    // Restart 50 cycles after the first trigger.
    $display("[TB] retrigger C0 then D0");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, 8'hC0);
    repeat (49) idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, 8'hD0);
    waitIdle(1000, 0);
    idleCycle();

    // Mid-transfer reset at index 10, together with a trigger write.
    $display("[TB] mid-transfer reset");
    for (int i = 0; i < LEN; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, DST + 16'(i), 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, 8'hC0);
    repeat (21) idleCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, REG, 8'h55);
    checkOutput("abortBusy", 32'(dmaBusy), 32'h0);
    repeat (4) idleCycle();
    for (int i = 0; i < LEN; i++)
      checkOutput("abortDst", 32'(mem[DST + 16'(i)]),
                  32'((i < 10) ? refMem[16'hC000 + 16'(i)] : 8'hA5));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, REG, 8'h00);

    // Randomized transfers with concurrent core traffic.
    $display("[TB] random transfers");
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, REG, (t == 0) ? 8'hFF : 8'($urandom));
      waitIdle(1000, 2);
      repeat (20) randomCycle(1'b0);
    end

    repeat (3) idleCycle();
    checkOutput("expRdDrained", 32'(expRd.size()), 32'h0);
    checkOutput("expWrDrained", 32'(expWr.size()), 32'h0);
    checkOutput("expCpuDrained", 32'(expCpu.size()), 32'h0);
    checkOutput("expBusyDrained", 32'(expBusy.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 Parameter DMA_REG, default 16'hFF46, address of the DMA trigger register.
REQ-002 Parameter DMA_LEN, default 160, number of bytes per transfer.
REQ-003 Parameter DMA_DST, default 16'hFE00, destination base address.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous reset, active-high, sampled on rising CLK.
REQ-006 cpu_mreq / cpu_rd / cpu_wr  in  1 each  core bus request, read strobe, write strobe.
REQ-007 cpu_a  in  16  core address; cpu_dout  in  8  core write data.
REQ-008 cpu_din  out  8  read data returned to core.
REQ-009 mem_mreq / mem_rd / mem_wr  out  1 each  memory port request and strobes.
REQ-010 mem_a  out  16  memory address; mem_dout  out  8  memory write data; mem_din  in  8  memory read data.
REQ-011 dma_busy  out  1  high while DMA owns the memory port.

Function
REQ-012 The block SHALL implement states IDLE, START, RD, WR; state, 8-bit page register P, 8-bit index I, and 8-bit data latch D are registered.
REQ-013 Trigger: a cycle with cpu_mreq & cpu_wr & cpu_a==DMA_REG SHALL load P<=cpu_dout, I<=0, and state<=START in any state.
REQ-014 Trigger writes SHALL NOT be forwarded to memory (mem_wr=0 that cycle when idle).
REQ-015 Read of DMA_REG (cpu_mreq & cpu_rd) SHALL return P on cpu_din in any state, without memory access.
REQ-016 START SHALL last exactly 1 cycle, then go to RD.
REQ-017 RD: mem_mreq=1, mem_rd=1, mem_a={S,I}, where S=P if P<8'hE0 else P-8'h20 (echo fold); D<=mem_din at cycle end; next WR.
REQ-018 WR: mem_mreq=1, mem_wr=1, mem_a=DMA_DST+I, mem_dout=D; if I==DMA_LEN-1 next IDLE, else I<=I+1, next RD.
REQ-019 Trigger in WR on the final byte SHALL still perform that write, then restart (START) rather than go IDLE.
REQ-020 Busy timing: trigger sampled at edge N -> START during cycle N+1, first RD during N+2; dma_busy high from N+1 through last WR, total 1+2*DMA_LEN cycles (321 by default).
REQ-021 dma_busy SHALL be 1 in START, RD, WR and 0 in IDLE (registered-state decode).
REQ-022 IDLE: mem_mreq/mem_rd/mem_wr/mem_a/mem_dout SHALL combinationally equal cpu_*, and cpu_din=mem_din (except REQ-014/015).
REQ-023 While busy: core reads (non-DMA_REG) SHALL return 8'hFF; core writes (non-DMA_REG) SHALL be dropped; no core strobe reaches memory.
REQ-024 In START, mem_mreq/mem_rd/mem_wr SHALL be 0.
REQ-025 I SHALL never exceed DMA_LEN-1; address arithmetic is 16-bit modulo.

Reset
REQ-026 RESET SHALL force state=IDLE, P=8'h00, I=0, D=8'h00, dma_busy=0; memory outputs then follow REQ-022.
REQ-027 RESET asserted mid-transfer SHALL abort immediately; no further DMA strobes after the reset edge; partially copied bytes remain.
REQ-028 RESET SHALL take priority over a simultaneous trigger write.

Verification
REQ-029 Idle passthrough: core read 16'h1234 with mem[1234]=8'h5A -> mem_a=16'h1234, mem_rd=1, cpu_din=8'h5A, dma_busy=0.
REQ-030 Full transfer: mem[C000..C09F]=i, write 8'hC0 to FF46 -> dma_busy high 321 cycles, mem[FE00..FE9F]=00..9F, then IDLE; FF46 read returns 8'hC0.
REQ-031 Echo fold: write 8'hE1 -> first RD mem_a=16'hC100.
REQ-032 Bus lockout: during DMA, core reads 16'h0100 -> 8'hFF; core writes 8'h77 to 16'hC000 -> memory unchanged, no mem_wr from core.
REQ-033 Restart: trigger 8'hC0, retrigger 8'hD0 after 50 cycles -> I resets to 0, next RD after START at 16'hD000, total busy ends 321 cycles after retrigger.
REQ-034 Mid-transfer reset: assert RESET at I=10 -> next cycle dma_busy=0, mem[FE00..FE09] written, FE0A onward untouched.
